// File: rtl/int_controller_pv_pkg.sv
// Shared encodings for the parametrised interrupt controller: handshake
// states and the reserved "no interrupt" ID.
package int_controller_pv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    localparam int NO_IRQ_ID = 0;

endpackage

// File: rtl/int_controller_pv_irq_channel.sv
// One interrupt channel: input synchroniser, previous-sample flop and sticky pending bit.
// Latency SYNC_STAGES+1 cycles from irq to pending; no backpressure (pending holds until cleared).
module int_controller_pv_irq_channel #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic irq,
    input  logic level,
    input  logic clr,
    input  logic grant,
    input  logic restore,
    output logic pending
);

    logic s;
    logic p;
    logic set_ev;

    generate
        if (SYNC_STAGES == 0) begin : g_bypass
            assign s = irq;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] chain;
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    chain <= '0;
                end else begin
                    chain[0] <= irq;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        chain[i] <= chain[i-1];
                    end
                end
            end
            assign s = chain[SYNC_STAGES-1];
        end
    endgenerate

    assign set_ev = level ? s : (s & ~p);

    // A new event (or a withdrawn grant) beats any clear in the same cycle,
    // so nothing arriving alongside its own grant is dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            p       <= 1'b0;
            pending <= 1'b0;
        end else begin
            p <= s;
            if (set_ev || restore) begin
                pending <= 1'b1;
            end else if (clr || grant) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/int_controller_pv.sv
// Fixed-priority interrupt controller (lowest channel wins, ID = channel+1) with IDLE/REQ/SERVICE handshake.
// int_cpu rises 1 cycle after pending; a REQ withdrawn by int_disabled re-pends its channel.
module int_controller_pv
    import int_controller_pv_pkg::*;
#(
    parameter int N_IRQ       = 10,
    parameter int ID_W        = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_IRQ-1:0] irq,
    input  logic [N_IRQ-1:0] irq_mask,
    input  logic [N_IRQ-1:0] irq_level,
    input  logic             int_disabled,
    input  logic             int_ack,
    input  logic             reti,
    input  logic [N_IRQ-1:0] clear_pending,
    output logic             int_cpu,
    output logic [ID_W-1:0]  int_id,
    output logic [N_IRQ-1:0] pending,
    output logic             in_service
);

    generate
        if (N_IRQ < 1 || N_IRQ > 64) begin : g_bad_n_irq
            $error("int_controller_pv: N_IRQ must be in 1..64");
        end
        if (ID_W < $clog2(N_IRQ + 1)) begin : g_bad_id_w
            $error("int_controller_pv: ID_W too narrow for N_IRQ+1 IDs");
        end
    endgenerate

    state_t           state_q, state_d;
    logic             int_cpu_d;
    logic [ID_W-1:0]  int_id_d;
    logic             in_service_d;
    logic [N_IRQ-1:0] eligible;
    logic [N_IRQ-1:0] win_onehot;
    logic [ID_W-1:0]  win_id;
    logic             win_vld;
    logic [N_IRQ-1:0] grant_vec;
    logic [N_IRQ-1:0] restore_vec;

    for (genvar g = 0; g < N_IRQ; g++) begin : g_chan
        int_controller_pv_irq_channel #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_irq_channel (
            .clk     (clk),
            .reset   (reset),
            .irq     (irq[g]),
            .level   (irq_level[g]),
            .clr     (clear_pending[g]),
            .grant   (grant_vec[g]),
            .restore (restore_vec[g]),
            .pending (pending[g])
        );
    end

    assign eligible = pending & irq_mask;

    // Scan downwards so the last hit is the lowest index.
    always_comb begin
        win_vld    = 1'b0;
        win_id     = ID_W'(NO_IRQ_ID);
        win_onehot = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                win_vld       = 1'b1;
                win_id        = ID_W'(i + 1);
                win_onehot    = '0;
                win_onehot[i] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        int_cpu_d    = int_cpu;
        int_id_d     = int_id;
        in_service_d = in_service;
        grant_vec    = '0;
        restore_vec  = '0;
        case (state_q)
            ST_IDLE: begin
                if (!int_disabled && win_vld) begin
                    state_d   = ST_REQ;
                    int_cpu_d = 1'b1;
                    int_id_d  = win_id;
                    grant_vec = win_onehot;
                end
            end
            ST_REQ: begin
                if (int_ack) begin
                    state_d      = ST_SERVICE;
                    int_cpu_d    = 1'b0;
                    in_service_d = 1'b1;
                end else if (int_disabled) begin
                    state_d   = ST_IDLE;
                    int_cpu_d = 1'b0;
                    int_id_d  = ID_W'(NO_IRQ_ID);
                    for (int i = 0; i < N_IRQ; i++) begin
                        restore_vec[i] = (int_id == ID_W'(i + 1));
                    end
                end
            end
            ST_SERVICE: begin
                if (reti) begin
                    state_d      = ST_IDLE;
                    in_service_d = 1'b0;
                    int_id_d     = ID_W'(NO_IRQ_ID);
                end
            end
            default: begin
                state_d      = ST_IDLE;
                int_cpu_d    = 1'b0;
                int_id_d     = ID_W'(NO_IRQ_ID);
                in_service_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            int_cpu    <= 1'b0;
            int_id     <= ID_W'(NO_IRQ_ID);
            in_service <= 1'b0;
        end else begin
            state_q    <= state_d;
            int_cpu    <= int_cpu_d;
            int_id     <= int_id_d;
            in_service <= in_service_d;
        end
    end

endmodule

// File: tb/tb_int_controller_pv.sv
// Directed bench for int_controller_pv: expected grant IDs are queued as stimulus is
// applied and popped when int_cpu rises; other checks are direct immediate assertions.
module tb_int_controller_pv;

    localparam int N_IRQ = 10;
    localparam int ID_W  = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic [N_IRQ-1:0] irq;
    logic [N_IRQ-1:0] irq_mask;
    logic [N_IRQ-1:0] irq_level;
    logic             int_disabled;
    logic             int_ack;
    logic             reti;
    logic [N_IRQ-1:0] clear_pending;
    logic             int_cpu;
    logic [ID_W-1:0]  int_id;
    logic [N_IRQ-1:0] pending;
    logic             in_service;

    int vectors     = 0;
    int miscompares = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    int_controller_pv #(
        .N_IRQ       (N_IRQ),
        .ID_W        (ID_W),
        .SYNC_STAGES (2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .irq           (irq),
        .irq_mask      (irq_mask),
        .irq_level     (irq_level),
        .int_disabled  (int_disabled),
        .int_ack       (int_ack),
        .reti          (reti),
        .clear_pending (clear_pending),
        .int_cpu       (int_cpu),
        .int_id        (int_id),
        .pending       (pending),
        .in_service    (in_service)
    );

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Wait up to max_cyc edges for int_cpu, then compare int_id with the scoreboard head.
    task automatic expect_grant(input string tag, input int max_cyc);
        int exp_id;
        int n;
        n = 0;
        while (n < max_cyc && int_cpu !== 1'b1) begin
            cyc(1);
            n++;
        end
        check({tag, "_int_cpu"}, 64'(int_cpu), 64'd1);
        exp_id = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        check({tag, "_id"}, 64'(int_id), 64'(exp_id));
    endtask

    task automatic ack_then_reti();
        int_ack = 1'b1;
        cyc(1);
        int_ack = 1'b0;
        cyc(1);
        reti = 1'b1;
        cyc(1);
        reti = 1'b0;
    endtask

    initial begin
        reset         = 1'b0;
        irq           = '0;
        irq_mask      = '1;
        irq_level     = '0;
        int_disabled  = 1'b0;
        int_ack       = 1'b0;
        reti          = 1'b0;
        clear_pending = '0;
        #12;
        check("rst_int_cpu", 64'(int_cpu), 64'd0);
        check("rst_int_id", 64'(int_id), 64'd0);
        check("rst_in_service", 64'(in_service), 64'd0);
        check("rst_pending", 64'(pending), 64'd0);
        reset = 1'b1;
        cyc(3);

        // Edge latency: irq[3] sampled at edge k, pending at k+2, int_cpu at k+3.
        irq[3] = 1'b1;
        exp_q.push_back(4);
        cyc(1);
        check("lat_pend_k", 64'(pending[3]), 64'd0);
        cyc(1);
        check("lat_pend_k1", 64'(pending[3]), 64'd0);
        cyc(1);
        check("lat_pend_k2", 64'(pending[3]), 64'd1);
        check("lat_cpu_k2", 64'(int_cpu), 64'd0);
        cyc(1);
        expect_grant("lat_k3", 0);
        check("lat_pend_cleared", 64'(pending[3]), 64'd0);
        irq[3]  = 1'b0;
        int_ack = 1'b1;
        cyc(1);
        int_ack = 1'b0;
        check("lat_ack_cpu", 64'(int_cpu), 64'd0);
        check("lat_ack_svc", 64'(in_service), 64'd1);
        check("lat_ack_id", 64'(int_id), 64'd4);
        cyc(2);
        check("lat_svc_no_grant", 64'(int_cpu), 64'd0);
        reti = 1'b1;
        cyc(1);
        reti = 1'b0;
        check("lat_reti_svc", 64'(in_service), 64'd0);
        check("lat_reti_id", 64'(int_id), 64'd0);
        cyc(3);
        check("lat_idle_cpu", 64'(int_cpu), 64'd0);

        // Priority: lower channel first, next grant one cycle after returning to IDLE.
        irq[5] = 1'b1;
        irq[1] = 1'b1;
        exp_q.push_back(2);
        exp_q.push_back(6);
        expect_grant("prio_first", 8);
        irq[5]  = 1'b0;
        irq[1]  = 1'b0;
        int_ack = 1'b1;
        cyc(1);
        int_ack = 1'b0;
        check("prio_pend5_waiting", 64'(pending[5]), 64'd1);
        reti = 1'b1;
        cyc(1);
        reti = 1'b0;
        check("prio_reti_cpu", 64'(int_cpu), 64'd0);
        cyc(1);
        expect_grant("prio_second", 0);
        ack_then_reti();
        cyc(2);

        // Withdrawal by int_disabled re-pends the channel.
        irq[6] = 1'b1;
        exp_q.push_back(7);
        expect_grant("wd_first", 8);
        irq[6]       = 1'b0;
        int_disabled = 1'b1;
        cyc(1);
        check("wd_cpu", 64'(int_cpu), 64'd0);
        check("wd_pend6", 64'(pending[6]), 64'd1);
        check("wd_id", 64'(int_id), 64'd0);
        cyc(2);
        check("wd_held_off", 64'(int_cpu), 64'd0);
        int_disabled = 1'b0;
        exp_q.push_back(7);
        expect_grant("wd_regrant", 1);
        // int_ack beats int_disabled in the same cycle.
        int_ack      = 1'b1;
        int_disabled = 1'b1;
        cyc(1);
        int_ack      = 1'b0;
        int_disabled = 1'b0;
        check("wd_ack_wins_svc", 64'(in_service), 64'd1);
        check("wd_ack_wins_pend", 64'(pending[6]), 64'd0);
        reti = 1'b1;
        cyc(1);
        reti = 1'b0;
        cyc(2);

        // Masked channel latches pending but is not granted until unmasked.
        irq_mask[2] = 1'b0;
        irq[2]      = 1'b1;
        cyc(1);
        irq[2] = 1'b0;
        cyc(5);
        check("mask_pend2", 64'(pending[2]), 64'd1);
        check("mask_no_cpu", 64'(int_cpu), 64'd0);
        irq_mask[2] = 1'b1;
        exp_q.push_back(3);
        expect_grant("mask_grant", 2);
        ack_then_reti();
        cyc(2);
        irq_mask[2] = 1'b0;
        irq[2]      = 1'b1;
        cyc(1);
        irq[2] = 1'b0;
        cyc(5);
        check("clr_pend_before", 64'(pending[2]), 64'd1);
        clear_pending[2] = 1'b1;
        cyc(1);
        clear_pending[2] = 1'b0;
        check("clr_pend_after", 64'(pending[2]), 64'd0);
        irq_mask[2] = 1'b1;
        cyc(5);
        check("clr_no_grant", 64'(int_cpu), 64'd0);

        // Level mode: re-pends while held and is re-granted one cycle after reti.
        irq_level[0] = 1'b1;
        irq[0]       = 1'b1;
        exp_q.push_back(1);
        expect_grant("lvl_first", 8);
        int_ack = 1'b1;
        cyc(1);
        int_ack = 1'b0;
        check("lvl_repend", 64'(pending[0]), 64'd1);
        reti = 1'b1;
        cyc(1);
        reti = 1'b0;
        check("lvl_reti_cpu", 64'(int_cpu), 64'd0);
        exp_q.push_back(1);
        expect_grant("lvl_second", 1);
        int_ack = 1'b1;
        cyc(1);
        int_ack = 1'b0;
        irq[0]  = 1'b0;
        cyc(4);
        clear_pending[0] = 1'b1;
        cyc(1);
        clear_pending[0] = 1'b0;
        reti = 1'b1;
        cyc(1);
        reti = 1'b0;
        cyc(5);
        check("lvl_dropped_cpu", 64'(int_cpu), 64'd0);
        check("lvl_dropped_pend", 64'(pending[0]), 64'd0);
        irq_level[0] = 1'b0;

        // Asynchronous reset between clock edges while in SERVICE with other work pending.
        irq[4] = 1'b1;
        exp_q.push_back(5);
        expect_grant("ar_grant", 8);
        irq[4]  = 1'b0;
        irq[8]  = 1'b1;
        int_ack = 1'b1;
        cyc(1);
        int_ack = 1'b0;
        irq[8]  = 1'b0;
        cyc(4);
        check("ar_pre_svc", 64'(in_service), 64'd1);
        check("ar_pre_pend", 64'(pending), 64'h100);
        #3;
        reset = 1'b0;
        #1;
        check("ar_cpu", 64'(int_cpu), 64'd0);
        check("ar_id", 64'(int_id), 64'd0);
        check("ar_svc", 64'(in_service), 64'd0);
        check("ar_pend", 64'(pending), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        cyc(6);
        check("ar_after_cpu", 64'(int_cpu), 64'd0);
        check("ar_after_pend", 64'(pending), 64'd0);

        check("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
